// File: rtl/out_ram_reader.sv
// out_ram_reader: drains the result RAM in address order onto a valid/ready stream
// through a 2-entry prefetch buffer. Define OUT_RAM_READER_CHECKSUM_EN to append an XOR checksum beat.
module out_ram_reader #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 2);
`ifdef OUT_RAM_READER_CHECKSUM_EN
  localparam int unsigned BEATS = DEPTH + 1;
`else
  localparam int unsigned BEATS = DEPTH;
`endif
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              buf_valid_c, hs_c, pop_c, credit_c, last_beat_c, start_c;
`ifdef OUT_RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_beat_c;
`endif

  // Stream side: buffer head (or checksum beat) and the read credit check.
  always_comb begin
    buf_valid_c = (occ_q != 2'd0);
`ifdef OUT_RAM_READER_CHECKSUM_EN
    csum_beat_c = (state_q == S_DRAIN) && (beat_q == CNT_W'(DEPTH));
    m_valid     = buf_valid_c || csum_beat_c;
    m_data      = csum_beat_c ? csum_q : fifo_q[rd_ptr_q];
`else
    m_valid     = buf_valid_c;
    m_data      = fifo_q[rd_ptr_q];
`endif
    last_beat_c = (beat_q == LAST_BEAT);
    m_last      = m_valid && last_beat_c;
    hs_c        = m_valid && m_ready;
    pop_c       = hs_c && buf_valid_c;
    // A pop this cycle frees a slot early enough to keep one beat per cycle.
    credit_c    = (3'(occ_q) + 3'(pend_q) - 3'(pop_c)) < 3'd2;
    start_c     = (state_q == S_IDLE) && start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FILL;
      S_FILL:  if (ram_rd && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN: if (hs_c && last_beat_c) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_rd = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      S_FILL: begin
        ram_rd = credit_c;
        busy   = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign ram_addr = addr_q;

  // Datapath: address counter, read-return tracking, 2-entry buffer, beat counter.
  always_comb begin
    addr_d   = addr_q;
    pend_d   = ram_rd;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + 2'(pend_q) - 2'(pop_c);
    beat_d   = beat_q;
`ifdef OUT_RAM_READER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (start_c) begin
      addr_d = '0;
      beat_d = '0;
`ifdef OUT_RAM_READER_CHECKSUM_EN
      csum_d = '0;
`endif
    end else begin
      if (ram_rd) addr_d = addr_q + ADDR_W'(1);
      if (hs_c)   beat_d = beat_q + CNT_W'(1);
`ifdef OUT_RAM_READER_CHECKSUM_EN
      if (pop_c)  csum_d = csum_q ^ fifo_q[rd_ptr_q];
`endif
    end
    if (pend_q) begin
      fifo_d[wr_ptr_q] = ram_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_c) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      pend_q   <= 1'b0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      beat_q   <= '0;
`ifdef OUT_RAM_READER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      beat_q   <= beat_d;
`ifdef OUT_RAM_READER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule
